aes_enc_arbiter: RTL and testbench
==================================

AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

Interface
REQ-001 Parameter PIPE_LAT, default 2, SHALL give cycles from the encrypt-pipe ready pulse to its valid result.
REQ-002 Parameter RSP_DEPTH, default 4, SHALL give entries per requester response FIFO (power of two, >=2).
REQ-003 clk  in  1  SHALL be the single clock; all state on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  in  2  SHALL flag a plaintext offered by requester i (bit i).
REQ-006 req0_data, req1_data  in  128 each  SHALL carry the plaintext blocks.
REQ-007 req_ready  out  2  SHALL flag acceptance of requester i in this cycle.
REQ-008 pipe_ready  out  1  SHALL drive the encrypt pipe's ready input.
REQ-009 pipe_data_in  out  128  SHALL drive the encrypt pipe's data input.
REQ-010 pipe_data_out  in  128  SHALL carry the ciphertext from the pipe.
REQ-011 pipe_valid  in  1  SHALL carry the pipe's result-valid flag.
REQ-012 rsp_valid  out  2  SHALL flag a ciphertext available to requester i.
REQ-013 rsp0_data, rsp1_data  out  128 each  SHALL carry the ciphertext at each FIFO head.
REQ-014 rsp_ready  in  2  SHALL flag requester i consuming its head.
REQ-015 err  out  1  SHALL be a sticky flag for a pipe result with no matching in-flight tag.

Function
REQ-016 Eligibility: requester i SHALL be eligible iff req_valid[i] and credit[i]>0, credit[i] = RSP_DEPTH - (fifo_count[i] + inflight[i]).
REQ-017 Grant: combinational round-robin; one eligible -> grant it; both eligible -> grant the one not granted most recently; RR pointer updates only on a grant.
REQ-018 req_ready[i] SHALL equal grant[i] (may depend on req_valid); at most one bit set per cycle.
REQ-019 On a grant, pipe_ready SHALL be 1 and pipe_data_in SHALL equal the granted reqN_data in the same cycle; otherwise pipe_ready=0, pipe_data_in=0.
REQ-020 Tag shift register of PIPE_LAT stages SHALL record {issued, id} each cycle; stage PIPE_LAT-1 aligns with pipe_valid.
REQ-021 pipe_valid with a valid tag SHALL push pipe_data_out into FIFO[id] on that edge; throughput one block per cycle sustained.
REQ-022 pipe_valid with no valid tag SHALL drop the data and set err; a valid tag with pipe_valid=0 SHALL also set err and release its credit.
REQ-023 Response FIFO: rsp_valid[i] = not empty; rspN_data = head; pop on rsp_valid[i]&rsp_ready[i]; simultaneous push and pop SHALL keep count unchanged.
REQ-024 Credits SHALL guarantee no push into a full FIFO; backpressure on rsp_ready SHALL stall only that requester's grants.
REQ-025 Latency: request accepted at edge t -> rsp_valid at edge t+PIPE_LAT+1 when FIFO empty.

Reset
REQ-026 On rst_n low, asynchronously: req_ready=0, pipe_ready=0, pipe_data_in=0, rsp_valid=0, rsp data=0, err=0, RR pointer favours requester 0, tags and FIFOs cleared.
REQ-027 Reset mid-operation SHALL discard all in-flight and buffered blocks; no response SHALL be emitted for them.

Configuration
REQ-028 With AES_ARB_PERF_EN defined, outputs issue_cnt0/issue_cnt1 (32 bit, wrap at 2^32, reset 0) SHALL count grants per requester; without it the ports and counters SHALL not exist.

Structure
REQ-029 Shared package aes_pkg SHALL hold AES_BLOCK_W=128 and the requester-id/tag typedef.
REQ-030 Response FIFO SHALL be sub-module aes_arb_rsp_fifo, instantiated twice.

Verification
REQ-031 Single request: req0 valid with 0x00112233...eeff, pipe model echoes XOR key -> rsp_valid[0] at t+3, data matches, rsp_valid[1]=0.
REQ-032 Both valid continuously 8 cycles, rsp_ready=11 -> grants alternate 0,1,0,1...; 4 responses each, in order.
REQ-033 rsp_ready[1]=0, req1 valid forever -> exactly RSP_DEPTH=4 grants to 1, then req_ready[1]=0 while requester 0 keeps flowing.
REQ-034 Inject pipe_valid with empty tag pipeline -> err=1 sticky, no FIFO push.
REQ-035 Reset asserted with 2 blocks in flight and 3 buffered -> all outputs 0 immediately, no responses after release.
REQ-036 AES_ARB_PERF_EN defined, 5 grants to 0 and 3 to 1 -> issue_cnt0=5, issue_cnt1=3.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES encrypt-pipe arbiter: block width and the tag carried alongside each issued block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: AES_BLOCK_W, NUM_REQ, req_id_t (requester index), tag_t ({issued, id} record per pipe slot).
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int NUM_REQ     = 2;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic    issued;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/aes_arb_rsp_fifo.sv
// Per-requester ciphertext response FIFO; head is presented combinationally, zero when empty.
// Latency: a block pushed at edge t is at the head from edge t; the pop takes effect on the next edge.
// Backpressure: pop is the consumer's ready; the arbiter's credits keep pushes away from a full FIFO.
// Ports: clk, rst_n (async active-low); push/push_data (write side); pop (consume head);
//        head_valid/head_data (read side); count (occupancy, feeds the credit calculation).
module aes_arb_rsp_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [AES_BLOCK_W-1:0]     push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [AES_BLOCK_W-1:0]     head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [AES_BLOCK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/aes_enc_arbiter.sv
// Round-robin arbiter sharing one fixed-latency AES encrypt pipe between two requesters, with per-requester response FIFOs.
// Latency: request granted in the cycle after edge t -> rsp_valid from edge t+PIPE_LAT+1 (empty FIFO).
// Backpressure: credit-based; a requester is granted only while FIFO occupancy plus in-flight blocks is below RSP_DEPTH.
// Ports: clk, rst_n; req_valid/req_ready/req0_data/req1_data (request side); pipe_ready/pipe_data_in/pipe_valid/
//        pipe_data_out (encrypt pipe); rsp_valid/rsp_ready/rsp0_data/rsp1_data (response side); err (sticky tag error).
// Optional: define AES_ARB_PERF_EN to add issue_cnt0/issue_cnt1 per-requester grant counters.
module aes_enc_arbiter
    import aes_pkg::*;
#(
    parameter int PIPE_LAT  = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    input  logic [AES_BLOCK_W-1:0] req0_data,
    input  logic [AES_BLOCK_W-1:0] req1_data,
    output logic [1:0]             req_ready,
    output logic                   pipe_ready,
    output logic [AES_BLOCK_W-1:0] pipe_data_in,
    input  logic [AES_BLOCK_W-1:0] pipe_data_out,
    input  logic                   pipe_valid,
    output logic [1:0]             rsp_valid,
    output logic [AES_BLOCK_W-1:0] rsp0_data,
    output logic [AES_BLOCK_W-1:0] rsp1_data,
    input  logic [1:0]             rsp_ready,
    output logic                   err
`ifdef AES_ARB_PERF_EN
    ,
    output logic [31:0]            issue_cnt0,
    output logic [31:0]            issue_cnt1
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int OCC_W = $clog2(RSP_DEPTH + PIPE_LAT + 1) + 1;

    tag_t                   tag_q [PIPE_LAT];
    tag_t                   tag_out;
    logic                   last_grant;
    logic [1:0]             elig;
    logic [1:0]             grant;
    logic [CNT_W-1:0]       fifo_cnt [NUM_REQ];
    logic [OCC_W-1:0]       occ      [NUM_REQ];
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0]             head_vld;

    assign tag_out = tag_q[PIPE_LAT-1];

    // Credit check: buffered plus in-flight blocks must leave room for one more.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            occ[i] = OCC_W'(fifo_cnt[i]);
            for (int k = 0; k < PIPE_LAT; k++) begin
                if (tag_q[k].issued && (tag_q[k].id == req_id_t'(i))) begin
                    occ[i] = occ[i] + OCC_W'(1);
                end
            end
            elig[i] = req_valid[i] && (occ[i] < OCC_W'(RSP_DEPTH));
        end
    end

    // last_grant==1 means requester 1 went last, so requester 0 wins a tie.
    // Grants are masked during reset so nothing is accepted while state is held clear.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready    = grant;
    assign pipe_ready   = |grant;
    assign pipe_data_in = grant[0] ? req0_data :
                          grant[1] ? req1_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            err        <= 1'b0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (|grant) last_grant <= grant[1];
            tag_q[0] <= '{issued: |grant, id: grant[1]};
            for (int k = 1; k < PIPE_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            // Result without a tag, or a tag whose result never came. A lost
            // result frees its credit simply by the tag leaving the pipeline.
            if (pipe_valid != tag_out.issued) err <= 1'b1;
        end
    end

    assign push[0] = pipe_valid && tag_out.issued && (tag_out.id == 1'b0);
    assign push[1] = pipe_valid && tag_out.issued && (tag_out.id == 1'b1);
    assign pop     = rsp_ready & head_vld;
    assign rsp_valid = head_vld;

    aes_arb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push[0]),
        .push_data  (pipe_data_out),
        .pop        (pop[0]),
        .head_valid (head_vld[0]),
        .head_data  (rsp0_data),
        .count      (fifo_cnt[0])
    );

    aes_arb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push[1]),
        .push_data  (pipe_data_out),
        .pop        (pop[1]),
        .head_valid (head_vld[1]),
        .head_data  (rsp1_data),
        .count      (fifo_cnt[1])
    );

`ifdef AES_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt0 <= '0;
            issue_cnt1 <= '0;
        end else begin
            if (grant[0]) issue_cnt0 <= issue_cnt0 + 32'd1;
            if (grant[1]) issue_cnt1 <= issue_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Directed self-checking bench for aes_enc_arbiter with a behavioural XOR-key encrypt pipe.
// Latency: pipe model returns each accepted block PIPE_LAT cycles after its ready pulse.
// Backpressure: rsp_ready is driven per step by the directed sequence.
module tb_aes_enc_arbiter;

    localparam int PL = 2;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [127:0] req0_data;
    logic [127:0] req1_data;
    logic [1:0]   req_ready;
    logic         pipe_ready;
    logic [127:0] pipe_data_in;
    logic [127:0] pipe_data_out;
    logic         pipe_valid;
    logic [1:0]   rsp_valid;
    logic [127:0] rsp0_data;
    logic [127:0] rsp1_data;
    logic [1:0]   rsp_ready;
    logic         err;
`ifdef AES_ARB_PERF_EN
    logic [31:0]  issue_cnt0;
    logic [31:0]  issue_cnt1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit inject = 0;
    bit mute   = 0;

    aes_enc_arbiter #(.PIPE_LAT(PL), .RSP_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req0_data     (req0_data),
        .req1_data     (req1_data),
        .req_ready     (req_ready),
        .pipe_ready    (pipe_ready),
        .pipe_data_in  (pipe_data_in),
        .pipe_data_out (pipe_data_out),
        .pipe_valid    (pipe_valid),
        .rsp_valid     (rsp_valid),
        .rsp0_data     (rsp0_data),
        .rsp1_data     (rsp1_data),
        .rsp_ready     (rsp_ready),
        .err           (err)
`ifdef AES_ARB_PERF_EN
        ,
        .issue_cnt0    (issue_cnt0),
        .issue_cnt1    (issue_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encrypt pipe model: "encryption" is XOR with KEY; driven on the falling edge.
    logic         mv [0:PL];
    logic [127:0] md [0:PL];
    initial begin
        pipe_valid    = 1'b0;
        pipe_data_out = '0;
        for (int k = 0; k <= PL; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int k = 0; k <= PL; k++) begin
                    mv[k] = 1'b0;
                    md[k] = '0;
                end
                pipe_valid    = 1'b0;
                pipe_data_out = '0;
            end else begin
                for (int k = PL; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    md[k] = md[k-1];
                end
                mv[0] = pipe_ready && !mute;
                md[0] = pipe_data_in ^ KEY;
                pipe_valid    = mv[PL] | inject;
                pipe_data_out = mv[PL] ? md[PL] : '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] d0(input int j);
        return {4{32'hA000_0000 | 32'(j)}};
    endfunction

    function automatic logic [127:0] d1(input int j);
        return {4{32'hB000_0000 | 32'(j)}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        inject    = 0;
        mute      = 0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_rr;
        logic [1:0] exp_rv;
        int         src;

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req0_data = '0;
        req1_data = '0;
        rsp_ready = 2'b00;

        // Reset state, with requests offered to prove grants are held off.
        #1;
        req_valid = 2'b11;
        req0_data = PT;
        req1_data = PT;
        #1;
        check("rst_req_ready",    128'(req_ready),    128'h0);
        check("rst_pipe_ready",   128'(pipe_ready),   128'h0);
        check("rst_pipe_data_in", pipe_data_in,       128'h0);
        check("rst_rsp_valid",    128'(rsp_valid),    128'h0);
        check("rst_rsp0_data",    rsp0_data,          128'h0);
        check("rst_rsp1_data",    rsp1_data,          128'h0);
        check("rst_err",          128'(err),          128'h0);
        do_reset();

        // Single request: response three edges after the grant edge.
        rsp_ready = 2'b11;
        step();
        req_valid = 2'b01;
        req0_data = PT;
        #1;
        check("single_req_ready",  128'(req_ready),  128'h1);
        check("single_pipe_ready", 128'(pipe_ready), 128'h1);
        check("single_pipe_data",  pipe_data_in,     PT);
        step();
        req_valid = 2'b00;
        #1;
        check("single_rsp_t1", 128'(rsp_valid), 128'h0);
        step();
        #1;
        check("single_rsp_t2", 128'(rsp_valid), 128'h0);
        step();
        #1;
        check("single_rsp_t3_valid", 128'(rsp_valid), 128'h1);
        check("single_rsp_t3_data",  rsp0_data, 128'h00102030405060708090a0b0c0d0e0f0);
        step();
        #1;
        check("single_rsp_popped", 128'(rsp_valid), 128'h0);

        // Both requesters continuously for 8 cycles: strict alternation, in-order responses.
        do_reset();
        rsp_ready = 2'b11;
        for (int j = 0; j < 12; j++) begin
            step();
            req_valid = (j < 8) ? 2'b11 : 2'b00;
            req0_data = d0(j);
            req1_data = d1(j);
            #1;
            exp_rr = (j < 8) ? ((j % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("rr_grant_%0d", j), 128'(req_ready), 128'(exp_rr));
            if (j < 8) begin
                check($sformatf("rr_pipe_data_%0d", j), pipe_data_in, (j % 2 == 0) ? d0(j) : d1(j));
            end
            exp_rv = 2'b00;
            if (j >= 3 && j - 3 < 8) begin
                src    = (j - 3) % 2;
                exp_rv = (src == 1) ? 2'b10 : 2'b01;
                if (src == 1) check($sformatf("rr_rsp1_data_%0d", j), rsp1_data, d1(j - 3) ^ KEY);
                else          check($sformatf("rr_rsp0_data_%0d", j), rsp0_data, d0(j - 3) ^ KEY);
            end
            check($sformatf("rr_rsp_valid_%0d", j), 128'(rsp_valid), 128'(exp_rv));
        end

        // Requester 1 never consumes: exactly four grants, then only requester 0 flows.
        do_reset();
        rsp_ready = 2'b01;
        for (int j = 0; j < 14; j++) begin
            step();
            req_valid = 2'b11;
            req0_data = d0(j);
            req1_data = d1(j);
            #1;
            exp_rr = (j < 8) ? ((j % 2 == 0) ? 2'b01 : 2'b10) : 2'b01;
            check($sformatf("bp_grant_%0d", j), 128'(req_ready), 128'(exp_rr));
        end
        step();
        req_valid = 2'b00;
        repeat (4) step();
        #1;
        check("bp_rsp_valid_held", 128'(rsp_valid), 128'h2);
        check("bp_rsp1_head_0",    rsp1_data, d1(1) ^ KEY);
        rsp_ready = 2'b11;
        step();
        #1;
        check("bp_rsp1_head_1", rsp1_data, d1(3) ^ KEY);
        step();
        #1;
        check("bp_rsp1_head_2", rsp1_data, d1(5) ^ KEY);
        step();
        #1;
        check("bp_rsp1_head_3", rsp1_data, d1(7) ^ KEY);
        step();
        #1;
        check("bp_drained", 128'(rsp_valid), 128'h0);

        // Result with no tag in flight: sticky err, nothing pushed.
        do_reset();
        step();
        #1;
        check("orphan_err_before", 128'(err), 128'h0);
        inject = 1;
        step();
        inject = 0;
        #1;
        check("orphan_err_set",  128'(err),       128'h1);
        check("orphan_no_push",  128'(rsp_valid), 128'h0);
        repeat (3) step();
        #1;
        check("orphan_err_sticky", 128'(err),       128'h1);
        check("orphan_no_push_2",  128'(rsp_valid), 128'h0);

        // Tag in flight but the pipe never answers: err once the tag reaches the last stage.
        do_reset();
        mute = 1;
        rsp_ready = 2'b11;
        step();
        req_valid = 2'b01;
        req0_data = PT;
        step();
        req_valid = 2'b00;
        step();
        #1;
        check("lost_err_early", 128'(err), 128'h0);
        step();
        #1;
        check("lost_err_set",  128'(err),       128'h1);
        check("lost_no_rsp",   128'(rsp_valid), 128'h0);
        mute = 0;

        // Reset mid-operation with 3 buffered and 2 in flight.
        do_reset();
        for (int j = 0; j < 5; j++) begin
            step();
            req_valid = 2'b11;
            req0_data = d0(j);
            req1_data = d1(j);
            #1;
            check($sformatf("mid_grant_%0d", j), 128'(req_ready), (j % 2 == 0) ? 128'h1 : 128'h2);
        end
        step();
        req_valid = 2'b00;
        #1;
        check("mid_buffered", 128'(rsp_valid), 128'h3);
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        check("mid_rst_req_ready",  128'(req_ready),  128'h0);
        check("mid_rst_pipe_ready", 128'(pipe_ready), 128'h0);
        check("mid_rst_pipe_data",  pipe_data_in,     128'h0);
        check("mid_rst_rsp_valid",  128'(rsp_valid),  128'h0);
        check("mid_rst_rsp0_data",  rsp0_data,        128'h0);
        check("mid_rst_rsp1_data",  rsp1_data,        128'h0);
        check("mid_rst_err",        128'(err),        128'h0);
        step();
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        rst_n     = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            #1;
            check($sformatf("mid_after_rsp_%0d", j), 128'(rsp_valid), 128'h0);
        end
        check("mid_after_err", 128'(err), 128'h0);

`ifdef AES_ARB_PERF_EN
        // Grant counters: 5 to requester 0, 3 to requester 1.
        do_reset();
        #1;
        check("perf_rst_cnt0", 128'(issue_cnt0), 128'h0);
        check("perf_rst_cnt1", 128'(issue_cnt1), 128'h0);
        rsp_ready = 2'b11;
        for (int j = 0; j < 8; j++) begin
            step();
            req_valid = (j < 5) ? 2'b01 : 2'b10;
            req0_data = d0(j);
            req1_data = d1(j);
        end
        step();
        req_valid = 2'b00;
        step();
        #1;
        check("perf_cnt0", 128'(issue_cnt0), 128'd5);
        check("perf_cnt1", 128'(issue_cnt1), 128'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
